// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the direct-mapped branch predictor: counter encodings,
// default table size and the sequential PC step.
package branch_predictor_pkg;

  localparam int          BP_DEFAULT_ENTRIES = 16;
  localparam logic [31:0] BP_PC_STEP         = 32'd4;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  // Fall-through PC; wraps naturally at 2^32.
  function automatic logic [31:0] bp_next_pc(input logic [31:0] pc);
    return pc + BP_PC_STEP;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// Two-bit saturating direction counter: one step toward the resolved outcome.
module bp_sat_ctr
  import branch_predictor_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr_t'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters. Fetch lookups are registered
// (one-cycle latency); execute updates train the table and raise a redirect pulse.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = BP_DEFAULT_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        u_valid,
  input  logic        u_is_branch,
  input  logic [31:0] u_pc,
  input  logic        u_taken,
  input  logic [31:0] u_target,
  input  logic        u_pred_taken,
  input  logic [31:0] u_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  ctr_t             r_ctr    [ENTRIES];

  // Fetch-side lookup reads the table as it stands before this edge's update.
  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic             w_f_taken;
  logic [31:0]      w_f_target;

  assign w_f_idx    = f_pc[IDX_W+1:2];
  assign w_f_tag    = f_pc[31:IDX_W+2];
  assign w_f_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_f_taken  = w_f_hit && r_ctr[w_f_idx][1];
  assign w_f_target = w_f_taken ? r_target[w_f_idx] : bp_next_pc(f_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= 32'h0000_0000;
    end else if (f_valid) begin
      pred_valid  <= 1'b1;
      pred_taken  <= w_f_taken;
      pred_target <= w_f_target;
    end else begin
      pred_valid  <= 1'b0;
    end
  end

  // Execute-side training.
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic             w_u_branch;
  ctr_t             w_u_ctr;
  ctr_t             w_u_ctr_next;

  assign w_u_idx    = u_pc[IDX_W+1:2];
  assign w_u_tag    = u_pc[31:IDX_W+2];
  assign w_u_hit    = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_u_branch = u_valid && u_is_branch;
  assign w_u_ctr    = r_ctr[w_u_idx];

  bp_sat_ctr u_sat_ctr (
    .ctr      (w_u_ctr),
    .taken    (u_taken),
    .ctr_next (w_u_ctr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 32'h0000_0000;
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (w_u_branch) begin
      if (w_u_hit) begin
        r_ctr[w_u_idx] <= w_u_ctr_next;
        if (u_taken) r_target[w_u_idx] <= u_target;
      end else if (u_taken) begin
        // Allocation evicts whatever aliased into this slot.
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= u_target;
        r_ctr[w_u_idx]    <= CTR_WT;
      end
    end
  end

  logic w_mispredict;

  assign w_mispredict = w_u_branch &&
                        ((u_taken != u_pred_taken) ||
                         (u_taken && (u_target != u_pred_target)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= 32'h0000_0000;
    end else begin
      mispredict <= w_mispredict;
      if (w_mispredict) redirect_pc <= u_taken ? u_target : bp_next_pc(u_pc);
    end
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of table entries; SHALL be a power of two, 4..256.
REQ-002 Parameter IDX_W, default log2(ENTRIES), index width; index SHALL be pc[IDX_W+1:2], tag SHALL be pc[31:IDX_W+2].
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 f_valid  input  1  fetch lookup request.
REQ-006 f_pc  input  32  fetch PC to predict.
REQ-007 pred_valid  output  1  prediction present, registered.
REQ-008 pred_taken  output  1  predicted direction.
REQ-009 pred_target  output  32  predicted next PC.
REQ-010 u_valid  input  1  resolved instruction from execute.
REQ-011 u_is_branch  input  1  resolved instruction is a conditional branch.
REQ-012 u_pc  input  32  PC of resolved instruction.
REQ-013 u_taken  input  1  actual outcome, driven by take_branch from execute.
REQ-014 u_target  input  32  actual taken target.
REQ-015 u_pred_taken  input  1  direction predicted at fetch, carried down the pipe.
REQ-016 u_pred_target  input  32  target predicted at fetch.
REQ-017 mispredict  output  1  one-cycle redirect pulse, registered.
REQ-018 redirect_pc  output  32  correct next PC, valid while mispredict=1.

Function
REQ-019 Each entry SHALL hold: valid bit, tag, 32-bit target, 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-020 Hit SHALL mean entry[idx].valid and stored tag equals pc tag.
REQ-021 Lookup latency SHALL be one cycle: f_valid at edge N gives pred_valid=1 after edge N+1.
REQ-022 pred_taken SHALL be hit and counter[1]; pred_target SHALL be stored target if pred_taken, else f_pc+4 (mod 2^32; 0xFFFFFFFC -> 0x00000000).
REQ-023 f_valid=0: pred_valid SHALL be 0 next cycle; pred_taken/pred_target SHALL hold.
REQ-024 u_valid and u_is_branch with hit: counter SHALL increment if u_taken, decrement otherwise, saturating at 11 and 00; target SHALL be written with u_target only if u_taken.
REQ-025 u_valid and u_is_branch, miss, u_taken: entry SHALL be allocated (overwriting any occupant) with valid=1, new tag, u_target, counter 10.
REQ-026 Miss with not taken: no table change.
REQ-027 u_valid=0 or u_is_branch=0: no table change, no mispredict.
REQ-028 Mispredict condition: u_valid and u_is_branch and (u_taken != u_pred_taken, or u_taken and u_target != u_pred_target).
REQ-029 mispredict SHALL assert for exactly one cycle after the edge sampling the condition; redirect_pc SHALL be u_target if u_taken else u_pc+4 (wrapping).
REQ-030 No mispredict: mispredict SHALL be 0; redirect_pc SHALL hold.
REQ-031 Lookup and update in the same cycle (any index, including same) SHALL return pre-update contents; no bypass.
REQ-032 Back-to-back updates to one entry SHALL each apply in order, one per cycle.

Reset
REQ-033 rst=1 SHALL immediately clear all valid bits, set all counters to 01, and drive pred_valid, pred_taken, mispredict to 0, pred_target and redirect_pc to 0x00000000.
REQ-034 Reset mid-operation SHALL abandon any in-flight lookup or update; first post-reset lookup SHALL miss.

Structure
REQ-035 Shared package SHALL hold counter encodings (SNT/WNT/WT/ST), default ENTRIES, and PC step 4.
REQ-036 Saturating 2-bit counter update SHALL be a sub-module bp_sat_ctr (inputs ctr, taken; output next ctr).

Verification
REQ-037 Reset then f_pc=0x00000100 -> pred_valid=1, pred_taken=0, pred_target=0x00000104.
REQ-038 Update u_pc=0x100, taken, u_target=0x80, u_pred_taken=0 -> mispredict pulse, redirect_pc=0x80; next lookup 0x100 -> taken, target 0x80.
REQ-039 Four taken updates at 0x100 then two not-taken -> counter 11 then 01; lookup predicts not taken, target 0x104.
REQ-040 Aliasing: entry at 0x100, taken update at 0x140 (same idx, ENTRIES=16) -> 0x140 replaces it; lookup 0x100 misses.
REQ-041 Same-cycle lookup and allocating update at 0x200 -> lookup returns miss, following lookup hits.
REQ-042 rst asserted between edges with valid entries -> outputs 0 without clock edge; all subsequent lookups miss.
